// File: rtl/mem_access_unit.sv
// Load/store front end for the 64-bit data RAM: turns byte-addressed requests into
// doubleword RAM accesses, with read-modify-write for partial stores and extended loads.
module mem_access_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+2:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              ram_cs,
    output logic              ram_memRead,
    output logic              ram_memWrite,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_writeData,
    input  logic [DATA_W-1:0] ram_readData
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        RESP
    } stateType;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    stateType          state;
    stateType          nextState;
    logic [ADDR_W+2:0] addrQ;
    logic [1:0]        sizeQ;
    logic              signedQ;
    logic              writeQ;
    logic              errorQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdataQ;

    logic              accept;
    logic              misaligned;
    logic [5:0]        laneShift;
    logic [DATA_W-1:0] laneMask;
    logic [DATA_W-1:0] shiftedRead;
    logic [DATA_W-1:0] loadResult;
    logic [DATA_W-1:0] mergedData;
    logic [DATA_W-1:0] storeData;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            SIZE_HALF:  misaligned = req_addr[0];
            SIZE_WORD:  misaligned = |req_addr[1:0];
            SIZE_DWORD: misaligned = |req_addr[2:0];
            default:    misaligned = 1'b0;
        endcase
    end

    // NOTE: state and registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addrQ   <= '0;
            sizeQ   <= SIZE_BYTE;
            signedQ <= 1'b0;
            writeQ  <= 1'b0;
            errorQ  <= 1'b0;
            wdataQ  <= '0;
            mdr     <= '0;
            rdataQ  <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrQ   <= req_addr;
                sizeQ   <= req_size;
                signedQ <= req_signed;
                writeQ  <= req_write;
                errorQ  <= misaligned;
                wdataQ  <= req_wdata;
            end
            if (state == CAPTURE) begin
                mdr <= ram_readData;
                if (!writeQ) begin
                    rdataQ <= loadResult;
                end
            end
        end
    end

    // NOTE: nextState is defaulted first so no latch is inferred on unlisted paths.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        nextState = RESP;
                    end else if (req_write && (req_size == SIZE_DWORD)) begin
                        nextState = WRITE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ:    nextState = CAPTURE;
            CAPTURE: nextState = writeQ ? WRITE : RESP;
            WRITE:   nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes depend only on the state register, never on the request inputs.
    always_comb begin
        ram_cs       = 1'b0;
        ram_memRead  = 1'b0;
        ram_memWrite = 1'b0;
        case (state)
            READ, CAPTURE: begin
                ram_cs      = 1'b1;
                ram_memRead = 1'b1;
            end
            WRITE: begin
                ram_cs       = 1'b1;
                ram_memWrite = 1'b1;
            end
            default: begin
                ram_cs       = 1'b0;
                ram_memRead  = 1'b0;
                ram_memWrite = 1'b0;
            end
        endcase
    end

    assign laneShift = {addrQ[2:0], 3'b000};

    always_comb begin
        laneMask = '0;
        case (sizeQ)
            SIZE_BYTE: laneMask = 64'h0000_0000_0000_00FF;
            SIZE_HALF: laneMask = 64'h0000_0000_0000_FFFF;
            SIZE_WORD: laneMask = 64'h0000_0000_FFFF_FFFF;
            default:   laneMask = '1;
        endcase
    end

    // Little-endian lanes: alignment guarantees the shifted lanes stay inside the doubleword.
    assign shiftedRead = ram_readData >> laneShift;

    always_comb begin
        loadResult = shiftedRead;
        case (sizeQ)
            SIZE_BYTE: loadResult = signedQ ? {{56{shiftedRead[7]}}, shiftedRead[7:0]}
                                            : {56'b0, shiftedRead[7:0]};
            SIZE_HALF: loadResult = signedQ ? {{48{shiftedRead[15]}}, shiftedRead[15:0]}
                                            : {48'b0, shiftedRead[15:0]};
            SIZE_WORD: loadResult = signedQ ? {{32{shiftedRead[31]}}, shiftedRead[31:0]}
                                            : {32'b0, shiftedRead[31:0]};
            default:   loadResult = shiftedRead;
        endcase
    end

    assign mergedData = (mdr & ~(laneMask << laneShift)) | ((wdataQ & laneMask) << laneShift);
    assign storeData  = (sizeQ == SIZE_DWORD) ? wdataQ : mergedData;

    assign ram_address   = (state != IDLE) ? addrQ[ADDR_W+2:3] : '0;
    assign ram_writeData = (state == WRITE) ? storeData : '0;

    assign resp_valid = (state == RESP);
    assign resp_error = (state == RESP) && errorQ;
    assign resp_rdata = rdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a synchronous-read RAM model and strobe monitors.
module tb_mem_access_unit;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+2:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_error;
    logic              ram_cs;
    logic              ram_memRead;
    logic              ram_memWrite;
    logic [ADDR_W-1:0] ram_address;
    logic [63:0]       ram_writeData;
    logic [63:0]       ram_readData;

    logic [63:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;
    int csCnt = 0;
    int rdCnt = 0;
    int wrCnt = 0;
    int respCnt = 0;
    int acceptCnt = 0;
    logic [ADDR_W-1:0] lastWrAddr = '0;
    logic [63:0]       lastWrData = '0;

    mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .ram_cs       (ram_cs),
        .ram_memRead  (ram_memRead),
        .ram_memWrite (ram_memWrite),
        .ram_address  (ram_address),
        .ram_writeData(ram_writeData),
        .ram_readData (ram_readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        ram_readData = '0;
    end

    always @(posedge clk) begin
        if (ram_cs && ram_memWrite) mem[ram_address] <= ram_writeData;
        if (ram_cs && ram_memRead)  ram_readData <= mem[ram_address];
        if (!rst && req_valid && req_ready) acceptCnt <= acceptCnt + 1;
    end

    always @(negedge clk) begin
        if (ram_cs) csCnt <= csCnt + 1;
        if (ram_cs && ram_memRead) rdCnt <= rdCnt + 1;
        if (ram_cs && ram_memWrite) begin
            wrCnt      <= wrCnt + 1;
            lastWrAddr <= ram_address;
            lastWrData <= ram_writeData;
        end
        if (resp_valid) respCnt <= respCnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after the accept edge; returns -1 when the budget expires.
    task automatic waitResp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [ADDR_W+2:0] a, input logic [63:0] wd,
                         output int lat, output logic [63:0] rd, output logic er);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        waitResp(lat);
        rd = resp_rdata;
        er = resp_error;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [63:0] rd;
        logic er;
        int wr0, rd0, cs0, resp0, acc0;

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset resp_error", 64'(resp_error), 64'd0);
        check("reset rdata", resp_rdata, 64'd0);
        check("reset strobes", {61'd0, ram_cs, ram_memRead, ram_memWrite}, 64'd0);
        check("reset address", 64'(ram_address), 64'd0);
        check("reset writeData", ram_writeData, 64'd0);

        // Dword store: single WRITE cycle, no read.
        wr0 = wrCnt; rd0 = rdCnt;
        issue(1'b1, 2'b11, 1'b0, 13'h180, 64'd10, lat, rd, er);
        check("dstore latency", 64'(lat), 64'd2);
        check("dstore error", 64'(er), 64'd0);
        check("dstore writes", 64'(wrCnt - wr0), 64'd1);
        check("dstore reads", 64'(rdCnt - rd0), 64'd0);
        check("dstore addr", 64'(lastWrAddr), 64'd48);
        check("dstore data", lastWrData, 64'd10);

        // Byte store: read-modify-write.
        wr0 = wrCnt; rd0 = rdCnt;
        issue(1'b1, 2'b00, 1'b0, 13'h183, 64'hAB, lat, rd, er);
        check("bstore latency", 64'(lat), 64'd4);
        check("bstore writes", 64'(wrCnt - wr0), 64'd1);
        check("bstore reads", 64'(rdCnt - rd0), 64'd2);
        check("bstore addr", 64'(lastWrAddr), 64'd48);
        check("bstore data", lastWrData, 64'h0000_0000_AB00_000A);

        wr0 = wrCnt;
        issue(1'b0, 2'b00, 1'b1, 13'h183, 64'd0, lat, rd, er);
        check("bload s latency", 64'(lat), 64'd3);
        check("bload s data", rd, 64'hFFFF_FFFF_FFFF_FFAB);
        check("bload s writes", 64'(wrCnt - wr0), 64'd0);
        issue(1'b0, 2'b00, 1'b0, 13'h183, 64'd0, lat, rd, er);
        check("bload u data", rd, 64'h0000_0000_0000_00AB);
        issue(1'b0, 2'b10, 1'b1, 13'h180, 64'd0, lat, rd, er);
        check("wload s data", rd, 64'hFFFF_FFFF_AB00_000A);
        issue(1'b0, 2'b10, 1'b0, 13'h180, 64'd0, lat, rd, er);
        check("wload u data", rd, 64'h0000_0000_AB00_000A);

        // Misaligned half load: no RAM activity, data held.
        cs0 = csCnt;
        issue(1'b0, 2'b01, 1'b1, 13'h181, 64'd0, lat, rd, er);
        check("mis half latency", 64'(lat), 64'd1);
        check("mis half error", 64'(er), 64'd1);
        check("mis half cs", 64'(csCnt - cs0), 64'd0);
        check("mis half rdata", rd, 64'h0000_0000_AB00_000A);

        // Half store in the top lanes, then loads across sizes.
        issue(1'b1, 2'b01, 1'b0, 13'h186, 64'h1234_BEEF, lat, rd, er);
        check("hstore data", lastWrData, 64'hBEEF_0000_AB00_000A);
        issue(1'b0, 2'b01, 1'b1, 13'h186, 64'd0, lat, rd, er);
        check("hload s data", rd, 64'hFFFF_FFFF_FFFF_BEEF);
        issue(1'b0, 2'b11, 1'b1, 13'h180, 64'd0, lat, rd, er);
        check("dload no ext", rd, 64'hBEEF_0000_AB00_000A);
        issue(1'b1, 2'b10, 1'b0, 13'h18C, 64'h8000_0001, lat, rd, er);
        check("wstore addr", 64'(lastWrAddr), 64'd49);
        check("wstore data", lastWrData, 64'h8000_0001_0000_0000);
        issue(1'b0, 2'b10, 1'b1, 13'h18C, 64'd0, lat, rd, er);
        check("wload hi s data", rd, 64'hFFFF_FFFF_8000_0001);

        // Other misalignments, including a store that must not write.
        wr0 = wrCnt; cs0 = csCnt;
        issue(1'b0, 2'b10, 1'b0, 13'h182, 64'd0, lat, rd, er);
        check("mis word error", 64'(er), 64'd1);
        issue(1'b1, 2'b11, 1'b0, 13'h184, 64'h1111, lat, rd, er);
        check("mis dword error", 64'(er), 64'd1);
        check("mis dword latency", 64'(lat), 64'd1);
        check("mis no ram", 64'(csCnt - cs0), 64'd0);
        check("mis rdata held", rd, 64'hFFFF_FFFF_8000_0001);

        // Highest doubleword index.
        issue(1'b1, 2'b11, 1'b0, 13'h1FF8, 64'h0123_4567_89AB_CDEF, lat, rd, er);
        check("top store addr", 64'(lastWrAddr), 64'd1023);
        issue(1'b0, 2'b11, 1'b0, 13'h1FF8, 64'd0, lat, rd, er);
        check("top load data", rd, 64'h0123_4567_89AB_CDEF);

        // Reset during CAPTURE of a partial store.
        wr0 = wrCnt; resp0 = respCnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 13'h180; req_wdata = 64'h55;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst in capture strobe", 64'(ram_memRead), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst ready", 64'(req_ready), 64'd1);
        check("rst strobes", {61'd0, ram_cs, ram_memRead, ram_memWrite}, 64'd0);
        rst = 1'b0;
        cs0 = csCnt;
        repeat (5) @(negedge clk);
        check("rst no write", 64'(wrCnt - wr0), 64'd0);
        check("rst no resp", 64'(respCnt - resp0), 64'd0);
        check("rst no strobe after", 64'(csCnt - cs0), 64'd0);
        check("rst mem unchanged", mem[48], 64'hBEEF_0000_AB00_000A);

        // Two loads with req_valid held continuously.
        acc0 = acceptCnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 13'h180;
        @(negedge clk);
        waitResp(lat);
        check("b2b first latency", 64'(lat), 64'd3);
        check("b2b first data", resp_rdata, 64'h0000_0000_0000_000A);
        check("b2b one accept", 64'(acceptCnt - acc0), 64'd1);
        check("b2b ready in resp", 64'(req_ready), 64'd0);
        req_size = 2'b10;
        req_addr = 13'h18C;
        @(negedge clk);
        check("b2b ready idle", 64'(req_ready), 64'd1);
        check("b2b still one accept", 64'(acceptCnt - acc0), 64'd1);
        @(negedge clk);
        waitResp(lat);
        req_valid = 1'b0;
        check("b2b second latency", 64'(lat), 64'd3);
        check("b2b second data", resp_rdata, 64'h0000_0000_8000_0001);
        check("b2b two accepts", 64'(acceptCnt - acc0), 64'd2);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the 64-bit data RAM in the multicycle datapath. It accepts one byte-addressed load or store per handshake from the control/datapath stage and converts it into doubleword-index accesses on the RAM port. Stores of byte, half and word size use an internal read-modify-write. Loads are returned sign- or zero-extended to 64 bits. It sits directly upstream of `data_ram` and owns `cs`, `address`, `memRead`, `memWrite` and `writeData`.

## Interface
- `ADDR_W`, 10, doubleword index width (RAM depth 2^ADDR_W)
- `DATA_W`, 64, RAM data width; fixed at 64
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request this cycle
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 dword
- `req_signed`  in  1  sign-extend load result (ignored for dword and stores)
- `req_addr`  in  ADDR_W+3  byte address
- `req_wdata`  in  64  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  64  load result; holds until next response
- `resp_error`  out  1  misaligned request; valid with `resp_valid`
- `ram_cs`, `ram_memRead`, `ram_memWrite`  out  1  RAM strobes
- `ram_address`  out  ADDR_W  doubleword index = `req_addr[ADDR_W+2:3]`
- `ram_writeData`  out  64  RAM write data
- `ram_readData`  in  64  RAM read data

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- The request is accepted when `req_valid & req_ready`. `req_ready` = (state == IDLE).
- Accept latches addr, size, signed, write and wdata into internal registers. Request inputs are ignored after accept.
- Misalignment check: the address must be a multiple of the size (half `addr[0]=0`, word `addr[1:0]=0`, dword `addr[2:0]=0`).
- Transitions from IDLE on accept:
  - misaligned → RESP, with `resp_error=1` and no RAM access
  - dword store → WRITE
  - all other accepted requests → READ
- READ → CAPTURE.
- CAPTURE → RESP for a load, WRITE for a partial store. The MDR latches `ram_readData` at the end of CAPTURE.
- WRITE → RESP. RESP → IDLE.
- Strobes are decoded from the state register only; there is no combinational path from `req_*`.
  - READ and CAPTURE: `ram_cs=1`, `ram_memRead=1`
  - WRITE: `ram_cs=1`, `ram_memWrite=1`
  - all other states: all strobes 0
- `ram_address` is driven from the latched address in every non-IDLE state.
- Lane mapping is little-endian: byte offset o = `addr[2:0]`, and the lane is bits [8o+7:8o].
- Partial store: `ram_writeData` = MDR with the addressed lanes replaced by the low bytes of `req_wdata`. Dword store: `ram_writeData` = `req_wdata`.
- Load: `resp_rdata` = the addressed lanes shifted to bit 0. The result is sign-extended if `req_signed` and size ≠ dword, otherwise zero-extended.
- Store and error responses leave `resp_rdata` unchanged.

## Timing
- Reset values: state=IDLE, `req_ready=1` (the cycle after the reset edge), `resp_valid=0`, `resp_error=0`, `resp_rdata=0`, all RAM strobes 0, `ram_address=0`, `ram_writeData=0`, MDR=0.
- Latency is counted from the accept edge to the cycle in which `resp_valid` is high:

  | Request | Latency (cycles) | RAM writes |
  |---|---|---|
  | misaligned | 1 | none |
  | dword store | 2 | 1 |
  | load | 3 | none |
  | partial store | 4 | 1 |

- Throughput: the next request can be accepted in the first IDLE cycle after RESP. There are no back-to-back accepts.
- Reset mid-operation: FSM → IDLE at that edge and any pending response is dropped. A write whose WRITE cycle coincides with `rst=1` may commit. No strobe is asserted in any cycle after the reset edge.
- `req_valid` is held while `req_ready=0`; no accept happens during this time.

## Test plan
- Dword store 64'd10 at byte addr 0x180 → one WRITE cycle: `ram_address=48`, `ram_writeData=10`, `ram_memRead` never high; `resp_valid` 2 cycles after accept, `resp_error=0`.
- Byte store 0xAB at 0x183 after the above → READ, CAPTURE, WRITE sequence. The write data is 64'h0000_0000_AB00_000A at address 48. `resp_valid` is high 4 cycles after accept.
- Byte load at 0x183 → `resp_rdata` = 64'hFFFF_FFFF_FFFF_FFAB with `req_signed=1`, 64'h0000_0000_0000_00AB with `req_signed=0`. Word load at 0x180 → 64'h0000_0000_AB00_000A.
- Half load at 0x181 → `resp_error=1` 1 cycle after accept. `ram_cs` stays 0 throughout and `resp_rdata` is unchanged.
- Reset asserted during CAPTURE of a partial store → no `ram_memWrite` at any time and no `resp_valid`. `req_ready=1` in the cycle after the reset edge, and RAM word 48 is unchanged.
- Two loads with `req_valid` held continuously → the second is accepted only in the IDLE cycle after the first RESP. Each response carries its own data.
